// File: rtl/fifo_uart_pkg.sv
// rtl/fifo_uart_pkg.sv - shared types and constants for the FIFO-fed serial transmitter
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
    STOP,
    PARITY
  } state_t;

  localparam int   DATA_W          = 8;
  localparam logic START_BIT       = 1'b0;
  localparam logic STOP_BIT        = 1'b1;
  localparam int   FRAME_BITS_BASE = 10;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - per-bit cycle counter; tick marks the last cycle of each serial bit
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  // Held at zero whenever not running so every bit period starts fresh.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (!run || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = run && (count == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - pops bytes from sync_fifo and sends them as 8N1 serial frames
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = fifo_uart_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              empty,
  output logic              read_en,
  input  logic [DATA_W-1:0] read_data,
  input  logic              tx_enable,
  output logic              tx,
  output logic              busy
);

  import fifo_uart_pkg::*;

  state_t            state, next_state;
  logic [DATA_W-1:0] shift_q;
  logic [2:0]        bit_idx, idx_d;
  logic              tx_d, read_en_d, busy_d;
  logic              run, tick;

  assign run = (state == START) || (state == DATA) || (state == STOP) || (state == PARITY);

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      tx      <= STOP_BIT;
      read_en <= 1'b0;
      busy    <= 1'b0;
      shift_q <= '0;
      bit_idx <= '0;
    end else begin
      state   <= next_state;
      tx      <= tx_d;
      read_en <= read_en_d;
      busy    <= busy_d;
      bit_idx <= idx_d;
      // FIFO data is valid the cycle after the pop, which is the LOAD cycle.
      if (state == LOAD) begin
        shift_q <= read_data;
      end
    end
  end

  always_comb begin
    next_state = state;
    idx_d      = bit_idx;
    case (state)
      IDLE:  if (!empty && tx_enable) next_state = POP;
      POP:   next_state = LOAD;
      LOAD:  next_state = START;
      START: if (tick) begin
        next_state = DATA;
        idx_d      = 3'd0;
      end
      DATA:  if (tick) begin
        if (bit_idx == 3'(DATA_W - 1)) begin
`ifdef FIFO_UART_TX_PARITY_EN
          next_state = PARITY;
`else
          next_state = STOP;
`endif
        end else begin
          idx_d = bit_idx + 3'd1;
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: if (tick) next_state = STOP;
`endif
      STOP:  if (tick) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so the registers line up with it.
  always_comb begin
    tx_d      = STOP_BIT;
    read_en_d = (next_state == POP);
    busy_d    = (next_state != IDLE);
    case (next_state)
      START:  tx_d = START_BIT;
      DATA:   tx_d = shift_q[idx_d];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: tx_d = ^shift_q;
`endif
      default: tx_d = STOP_BIT;
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - directed self-checking bench for fifo_uart_tx with a small FIFO model
module tb_fifo_uart_tx;

  import fifo_uart_pkg::*;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       empty;
  logic       read_en;
  logic [7:0] read_data = 8'h00;
  logic       tx_enable = 1'b0;
  logic       tx;
  logic       busy;

  logic [7:0] mem [16];
  logic [3:0] wr = 4'd0;
  logic [3:0] rd = 4'd0;
  logic       flush = 1'b0;

  int checks = 0;
  int failures = 0;
  int pops = 0;
  int bad_pops = 0;
  int cyc = 0;
  int start_cyc = 0;
  int end_cyc = 0;
  int gap = 0;
  logic got;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .empty     (empty),
    .read_en   (read_en),
    .read_data (read_data),
    .tx_enable (tx_enable),
    .tx        (tx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  assign empty = (wr == rd);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (flush) begin
      rd <= wr;
    end else if (read_en) begin
      read_data <= mem[rd];
      rd        <= rd + 4'd1;
    end
  end

  always @(negedge clk) begin
    if (read_en) pops <= pops + 1;
    if (reset && read_en && empty) bad_pops <= bad_pops + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr] = b;
    wr = wr + 4'd1;
  endtask

  // Waits for the pop, then checks every cycle of the frame against the expected bit pattern.
  task automatic frame_check(input logic [7:0] b, input int drop_k);
    logic [10:0] exp_bits;
    int nb;
    logic seen;
    exp_bits = '1;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[i+1] = b[i];
    nb = FRAME_BITS_BASE;
`ifdef FIFO_UART_TX_PARITY_EN
    exp_bits[9]  = ^b;
    exp_bits[10] = 1'b1;
    nb = FRAME_BITS_BASE + 1;
`endif
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (read_en === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    chk($sformatf("pop_seen_%02h", b), 32'(seen), 32'd1);
    if (!seen) return;
    chk($sformatf("pop_busy_%02h", b), 32'(busy), 32'd1);
    chk($sformatf("pop_tx_%02h", b), 32'(tx), 32'd1);
    @(negedge clk);
    chk($sformatf("load_tx_%02h", b), 32'(tx), 32'd1);
    chk($sformatf("load_rden_%02h", b), 32'(read_en), 32'd0);
    @(negedge clk);
    start_cyc = cyc;
    for (int k = 0; k < nb; k++) begin
      for (int c = 0; c < CPB; c++) begin
        if (k == drop_k && c == 0) tx_enable = 1'b0;
        chk($sformatf("tx_%02h_bit%0d_c%0d", b, k, c), 32'(tx), 32'(exp_bits[k]));
        if (c == 0) chk($sformatf("busy_%02h_bit%0d", b, k), 32'(busy), 32'd1);
        @(negedge clk);
      end
    end
    end_cyc = cyc;
    chk($sformatf("busy_end_%02h", b), 32'(busy), 32'd0);
    chk($sformatf("tx_end_%02h", b), 32'(tx), 32'd1);
  endtask

  initial begin
    // 1: reset held with data waiting and enable high
    push(8'h3C);
    tx_enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_rden", 32'(read_en), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    tx_enable = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("dis_rden", 32'(read_en), 32'd0);
    end
    chk("dis_pops", 32'(pops), 32'd0);
    chk("dis_not_empty", 32'(empty), 32'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    chk("flush_empty", 32'(empty), 32'd1);

    // 2: single frame
    push(8'hA5);
    tx_enable = 1'b1;
    frame_check(8'hA5, -1);
    chk("single_pops", 32'(pops), 32'd1);
    chk("single_empty", 32'(empty), 32'd1);

    // 3: back-to-back with minimum gap
    push(8'h00);
    push(8'hFF);
    frame_check(8'h00, -1);
    gap = end_cyc;
    frame_check(8'hFF, -1);
    chk("b2b_gap", 32'(start_cyc - gap), 32'd3);
    chk("b2b_pops", 32'(pops), 32'd3);

    // 4: empty guard
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("guard_rden", 32'(read_en), 32'd0);
      chk("guard_tx", 32'(tx), 32'd1);
    end

    // 5a: enable drops during data bit 3
    push(8'h55);
    push(8'h99);
    frame_check(8'h55, 4);
    repeat (20) @(negedge clk);
    chk("drop_pops", 32'(pops), 32'd4);
    chk("drop_not_empty", 32'(empty), 32'd0);
    chk("drop_tx", 32'(tx), 32'd1);

    // 5b: reset during data bit 5 of 0x99
    tx_enable = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (read_en === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    chk("rst_mid_pop", 32'(got), 32'd1);
    repeat (2 + CPB * 6 + 2) @(negedge clk);
    chk("rst_mid_bit5", 32'(tx), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_mid_tx", 32'(tx), 32'd1);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_rden", 32'(read_en), 32'd0);
    chk("rst_mid_state", 32'(dut.state), 32'(IDLE));
    @(negedge clk);
    reset = 1'b1;
    chk("rst_mid_empty", 32'(empty), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_tx", 32'(tx), 32'd1);
    end

`ifdef FIFO_UART_TX_PARITY_EN
    // 6: parity frames
    push(8'h07);
    frame_check(8'h07, -1);
    chk("par07_len", 32'(end_cyc - start_cyc), 32'd44);
    push(8'h03);
    frame_check(8'h03, -1);
    chk("par03_len", 32'(end_cyc - start_cyc), 32'd44);
`else
    push(8'h07);
    frame_check(8'h07, -1);
    chk("len07", 32'(end_cyc - start_cyc), 32'd40);
`endif

    chk("no_pop_when_empty", 32'(bad_pops), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Read-side consumer of sync_fifo. It pops bytes from the FIFO whenever the FIFO is non-empty and transmission is enabled, then serializes each byte onto an asynchronous-serial TX line: 1 start bit, 8 data bits LSB first, 1 stop bit. It sits directly downstream of sync_fifo, connected to its empty, read_en and read_data signals, and drives the chip-level serial output.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; legal values are >= 2.
DATA_W, 8, byte width; fixed at 8 to match the FIFO.

Ports:
clk  input  1  system clock; all logic is on its rising edge.
reset  input  1  asynchronous, active-low reset.
empty  input  1  FIFO empty flag from sync_fifo.
read_en  output  1  one-cycle pop request to sync_fifo.
read_data  input  8  FIFO data, valid the cycle after read_en is high.
tx_enable  input  1  when high, new frames may start.
tx  output  1  serial line; idles high.
busy  output  1  high from the pop cycle through the last stop-bit cycle.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, tx=1, read_en=0, busy=0.
  - Baud counter, bit index and shift register all cleared.
- All outputs are registered.
- States: IDLE, POP, LOAD, START, DATA, STOP (plus PARITY when the optional feature is enabled).
- IDLE:
  - tx=1, busy=0.
  - If empty==0 and tx_enable==1, go to POP; otherwise stay in IDLE.
- POP:
  - Exactly one cycle, with read_en=1 and busy=1.
  - Next state is LOAD.
- LOAD:
  - One cycle; shift register <= read_data. read_en=0.
  - Next state is START.
- START:
  - tx=0 for CLKS_PER_BIT cycles.
  - Next state is DATA, with bit index=0.
- DATA:
  - tx = shift register bit[index] for CLKS_PER_BIT cycles per bit.
  - Index increments 0..7; after bit 7 go to STOP (or PARITY).
- STOP:
  - tx=1 for CLKS_PER_BIT cycles, then IDLE.
- Timing:
  - First start-bit cycle is 3 clocks after the IDLE cycle that sampled the condition.
  - Frame length is 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).
  - Minimum idle-high gap between back-to-back frames is 3 cycles (IDLE, POP, LOAD).
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - No count is carried across states.
- Boundaries:
  - read_en is never asserted while empty==1.
  - At most one pop per frame; no pop while busy.
  - tx_enable falling mid-frame: the current frame completes and no new frame starts.
  - tx_enable rising while in IDLE with empty==0: POP follows on the next cycle.
  - empty rising after POP has no effect; the popped byte is always transmitted.
  - Reset mid-frame: tx goes to 1 immediately and the in-flight byte is discarded (it was already popped).

Optional Feature:
Macro: FIFO_UART_TX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP.
  - tx = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles.
  - Frame is 11 bits.
- Undefined:
  - The PARITY state and its logic are absent.
  - Frame is 10 bits.

Decomposition:
- Package fifo_uart_pkg contains:
  - state enum typedef (IDLE, POP, LOAD, START, DATA, STOP, PARITY);
  - constant DATA_W=8;
  - constants START_BIT=1'b0 and STOP_BIT=1'b1;
  - constant FRAME_BITS_BASE=10.
- One sub-module: uart_baud_tick. It holds the CLKS_PER_BIT counter and has ports clk, reset, run and tick. tick is high on the last cycle of each bit.

Test Plan:
1. Reset behaviour: with CLKS_PER_BIT=4, reset low while FIFO holds 0x3C. Expect tx=1, read_en=0, busy=0 throughout; after reset release with tx_enable=0, no pop occurs.
2. Single frame: FIFO holds 0xA5, tx_enable=1. Expect one read_en pulse; 3 cycles later tx shows 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles (40 cycles total); busy falls after the stop bit; empty=1 afterwards.
3. Back-to-back: FIFO holds 0x00 then 0xFF. Expect exactly 2 read_en pulses, frames 0,00000000,1 then 0,11111111,1, and exactly a 3-cycle idle-high gap between them.
4. Empty guard: empty=1 with tx_enable=1 for 100 cycles. Expect read_en=0 and tx=1 throughout.
5. Enable and reset mid-frame: drop tx_enable during data bit 3 of 0x55. Expect the full frame to complete and no further pop. Then restart a frame and assert reset during bit 5. Expect tx=1 in the same cycle and state=IDLE.
6. Parity (FIFO_UART_TX_PARITY_EN defined): byte 0x07 gives parity bit 1 before stop (11 bits, 44 cycles); byte 0x03 gives parity bit 0.
